// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings for the multi-cycle control unit
// Purpose: state encodings, opcode values, ALU operation codes and the
//          instruction-class type used by cu_decoder and mc_control_unit.
// Ports:   none (package).
package cu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [2:0] {
    CL_ALU_R,
    CL_ALU_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_HALT,
    CL_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - opcode to instruction class and static datapath controls
// Purpose: purely combinational decode of the IR opcode.
// Ports:   opcode    - instruction opcode (IR[31:26])
//          iclass    - instruction class driving the sequencer
//          ext_sel   - 1 sign-extend, 0 zero-extend the immediate
//          alu_src_b - 1 immediate, 0 rt as ALU operand B
//          alu_op    - ALU operation code
//          reg_dst   - 1 rd, 0 rt as write-back register
// Config:  CU_JUMP_EN - decode 111000 as J; otherwise it is illegal.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output iclass_t        iclass,
  output logic           ext_sel,
  output logic           alu_src_b,
  output logic [2:0]     alu_op,
  output logic           reg_dst
);

  always_comb begin
    iclass    = CL_ILLEGAL;
    ext_sel   = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    reg_dst   = 1'b0;
    case (opcode)
      OP_ADD:  begin iclass = CL_ALU_R; reg_dst = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:  begin iclass = CL_ALU_R; reg_dst = 1'b1; alu_op = ALU_SUB; end
      OP_OR:   begin iclass = CL_ALU_R; reg_dst = 1'b1; alu_op = ALU_OR;  end
      OP_AND:  begin iclass = CL_ALU_R; reg_dst = 1'b1; alu_op = ALU_AND; end
      OP_SLT:  begin iclass = CL_ALU_R; reg_dst = 1'b1; alu_op = ALU_SLT; end
      OP_ADDI: begin iclass = CL_ALU_I; ext_sel = 1'b1; alu_src_b = 1'b1; alu_op = ALU_ADD; end
      OP_ORI:  begin iclass = CL_ALU_I; alu_src_b = 1'b1; alu_op = ALU_OR; end
      OP_LW:   begin iclass = CL_LOAD;  ext_sel = 1'b1; alu_src_b = 1'b1; alu_op = ALU_ADD; end
      OP_SW:   begin iclass = CL_STORE; ext_sel = 1'b1; alu_src_b = 1'b1; alu_op = ALU_ADD; end
      OP_BEQ,
      OP_BNE:  begin iclass = CL_BRANCH; ext_sel = 1'b1; alu_op = ALU_SUB; end
`ifdef CU_JUMP_EN
      OP_J:    iclass = CL_JUMP;
`endif
      OP_HALT: iclass = CL_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle instruction sequencer for the MIPS-style CPU
// Purpose: steps each instruction through IF/ID/EXE/MEM/WB (or HALT) and drives
//          PC, IR, register-file, ALU and data-memory controls.
// Ports:   CLK, Reset (async, active-low); opcode, Zero in;
//          PCWre, PCSrc, IRWre, ExtSel, ALUSrcB, ALUOp, RegDst, RegWre,
//          MemRd, MemWr, DBDataSrc, Jump (CU_JUMP_EN only), state out.
// Config:  CU_JUMP_EN - adds the J instruction and the Jump port.
module mc_control_unit
  import cu_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] opcode,
  input  logic           Zero,
  output logic           PCWre,
  output logic           PCSrc,
  output logic           IRWre,
  output logic           ExtSel,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           RegDst,
  output logic           RegWre,
  output logic           MemRd,
  output logic           MemWr,
  output logic           DBDataSrc,
`ifdef CU_JUMP_EN
  output logic           Jump,
`endif
  output logic [2:0]     state
);

  state_t     cur_state, next_state;
  iclass_t    iclass;
  logic       dec_ext_sel, dec_alu_src_b, dec_reg_dst;
  logic [2:0] dec_alu_op;
  logic       is_bne;

  cu_decoder #(.OPW(OPW)) u_decoder (
    .opcode    (opcode),
    .iclass    (iclass),
    .ext_sel   (dec_ext_sel),
    .alu_src_b (dec_alu_src_b),
    .alu_op    (dec_alu_op),
    .reg_dst   (dec_reg_dst)
  );

  assign is_bne = (opcode == OP_BNE);
  assign state  = cur_state;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cur_state <= S_IF;
    else        cur_state <= next_state;
  end

  // PC controls depend only on the registered state, the decoded opcode and
  // Zero, so they settle early enough for the falling-edge PC capture.
  // Every output is gated by Reset so nothing leaks while reset is held.
  always_comb begin
    next_state = S_IF;
    PCWre      = 1'b0;
    PCSrc      = 1'b0;
    IRWre      = 1'b0;
    ExtSel     = 1'b0;
    ALUSrcB    = 1'b0;
    ALUOp      = 3'b000;
    RegDst     = 1'b0;
    RegWre     = 1'b0;
    MemRd      = 1'b0;
    MemWr      = 1'b0;
    DBDataSrc  = 1'b0;
`ifdef CU_JUMP_EN
    Jump       = 1'b0;
`endif

    case (cur_state)
      S_IF:  next_state = S_ID;
      S_ID: begin
        case (iclass)
          CL_HALT:               next_state = S_HALT;
          CL_JUMP, CL_ILLEGAL:   next_state = S_IF;
          default:               next_state = S_EXE;
        endcase
      end
      S_EXE: begin
        case (iclass)
          CL_BRANCH:             next_state = S_IF;
          CL_LOAD, CL_STORE:     next_state = S_MEM;
          default:               next_state = S_WB;
        endcase
      end
      S_MEM:  next_state = (iclass == CL_LOAD) ? S_WB : S_IF;
      S_WB:   next_state = S_IF;
      S_HALT: next_state = S_HALT;
      default: next_state = S_IF;
    endcase

    if (Reset) begin
      IRWre = (cur_state == S_IF);

      // One PCWre per instruction, in whichever state finishes it.
      PCWre = ((cur_state == S_ID)  && (iclass == CL_JUMP || iclass == CL_ILLEGAL)) ||
              ((cur_state == S_EXE) && (iclass == CL_BRANCH)) ||
              ((cur_state == S_MEM) && (iclass == CL_STORE)) ||
              (cur_state == S_WB);

      PCSrc = (cur_state == S_EXE) && (iclass == CL_BRANCH) && (is_bne ? !Zero : Zero);

      if (cur_state == S_ID || cur_state == S_EXE || cur_state == S_MEM || cur_state == S_WB) begin
        ExtSel  = dec_ext_sel;
        ALUSrcB = dec_alu_src_b;
        ALUOp   = dec_alu_op;
        RegDst  = dec_reg_dst;
      end

      RegWre    = (cur_state == S_WB);
      MemRd     = (cur_state == S_MEM) && (iclass == CL_LOAD);
      MemWr     = (cur_state == S_MEM) && (iclass == CL_STORE);
      DBDataSrc = (cur_state == S_WB)  && (iclass == CL_LOAD);
`ifdef CU_JUMP_EN
      Jump      = (cur_state == S_ID)  && (iclass == CL_JUMP);
`endif
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized self-checking bench for mc_control_unit
module tb_mc_control_unit;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EXE = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;
`ifdef CU_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] opcode;
  logic       Zero;
  logic       PCWre, PCSrc, IRWre, ExtSel, ALUSrcB, RegDst, RegWre, MemRd, MemWr, DBDataSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;
`ifdef CU_JUMP_EN
  logic       Jump;
`endif

  int total = 0;
  int bad   = 0;
  int pcw_count;

  logic [5:0] legal_ops [11] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                 6'b010010, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
                                 6'b110101};

  mc_control_unit #(.OPW(6)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .Zero(Zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ExtSel(ExtSel),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .RegWre(RegWre),
    .MemRd(MemRd), .MemWr(MemWr), .DBDataSrc(DBDataSrc),
`ifdef CU_JUMP_EN
    .Jump(Jump),
`endif
    .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_j(input logic [5:0] op);
    return JEN && (op == 6'b111000);
  endfunction

  function automatic bit is_decoded(input logic [5:0] op);
    bit hit = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) hit = 1'b1;
    return hit;
  endfunction

  // Cycles each instruction takes, from the CPI table.
  function automatic int cpi(input logic [5:0] op);
    if (op == 6'b111111) return 1000;
    if (!is_decoded(op)) return 2;
    case (op)
      6'b110001:            return 5;
      6'b110000:            return 4;
      6'b110100, 6'b110101: return 3;
      default:              return 4;
    endcase
  endfunction

  // k-th state visited by the instruction.
  function automatic logic [2:0] path_state(input logic [5:0] op, input int k);
    if (k == 0) return ST_IF;
    if (k == 1) return ST_ID;
    if (op == 6'b111111) return ST_HALT;
    if (k == 2) return ST_EXE;
    if (k == 3 && (op == 6'b110001 || op == 6'b110000)) return ST_MEM;
    return ST_WB;
  endfunction

  // {ExtSel, ALUSrcB, ALUOp, RegDst}
  function automatic logic [5:0] exp_dp(input logic [5:0] op);
    case (op)
      6'b000000: return {1'b0, 1'b0, 3'b000, 1'b1};
      6'b000001: return {1'b0, 1'b0, 3'b001, 1'b1};
      6'b000010: return {1'b1, 1'b1, 3'b000, 1'b0};
      6'b010000: return {1'b0, 1'b0, 3'b011, 1'b1};
      6'b010001: return {1'b0, 1'b0, 3'b100, 1'b1};
      6'b010010: return {1'b0, 1'b1, 3'b011, 1'b0};
      6'b100111: return {1'b0, 1'b0, 3'b110, 1'b1};
      6'b110000,
      6'b110001: return {1'b1, 1'b1, 3'b000, 1'b0};
      default:   return {1'b1, 1'b0, 3'b001, 1'b0};
    endcase
  endfunction

  function automatic logic [7:0] act_strobes();
    logic j = 1'b0;
`ifdef CU_JUMP_EN
    j = Jump;
`endif
    return {PCWre, PCSrc, IRWre, RegWre, MemRd, MemWr, DBDataSrc, j};
  endfunction

  task automatic do_step(input logic [5:0] op, input int k, input logic z);
    logic [2:0] s;
    bit         last, br;
    logic [7:0] exp;
    Zero = z;
    #1;
    s    = path_state(op, k);
    last = (k == cpi(op) - 1);
    br   = (op == 6'b110100) || (op == 6'b110101);
    exp  = {last,
            last && br && ((op == 6'b110100) ? z : !z),
            s == ST_IF,
            s == ST_WB,
            s == ST_MEM && op == 6'b110001,
            s == ST_MEM && op == 6'b110000,
            s == ST_WB && op == 6'b110001,
            s == ST_ID && is_j(op)};
    check("state", 8'(state), 8'(s));
    check("strobes", act_strobes(), exp);
    if (s != ST_IF && s != ST_HALT && is_decoded(op))
      check("datapath", 8'({ExtSel, ALUSrcB, ALUOp, RegDst}), 8'(exp_dp(op)));
    pcw_count += int'(PCWre);
  endtask

  // zmode: 0/1 fixed Zero, 2 random Zero every cycle.
  task automatic run_instr(input logic [5:0] op, input int zmode);
    logic z;
    opcode    = op;
    pcw_count = 0;
    for (int k = 0; k < cpi(op); k++) begin
      z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      do_step(op, k, z);
      @(negedge CLK);
    end
    check("pcwre_pulses", 8'(pcw_count), 8'd1);
  endtask

  function automatic logic [5:0] pick_op();
    int r = $urandom_range(0, 12);
    logic [5:0] op;
    if (r <= 10) return legal_ops[r];
    if (r == 11) return 6'b111000;
    op = 6'b001111;
    for (int t = 0; t < 100; t++) begin
      op = 6'($urandom);
      if (!is_decoded(op) && op != 6'b111111 && op != 6'b111000) return op;
    end
    return 6'b001111;
  endfunction

  initial begin
    Reset  = 1'b0;
    opcode = 6'b000000;
    Zero   = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset_state", 8'(state), 8'd0);
    check("reset_strobes", act_strobes(), 8'd0);
    check("reset_dp", 8'({ExtSel, ALUSrcB, ALUOp, RegDst}), 8'd0);
    @(negedge CLK);
    Reset = 1'b1;

    // directed
    run_instr(6'b000000, 2);
    run_instr(6'b110001, 2);
    run_instr(6'b110000, 2);
    run_instr(6'b110100, 1);
    run_instr(6'b110100, 0);
    run_instr(6'b110101, 0);
    run_instr(6'b110101, 1);
    run_instr(6'b111000, 2);
    run_instr(6'b001111, 2);

    // reset mid-EXE of an ADD
    opcode = 6'b000000;
    do_step(6'b000000, 0, 1'b0);
    @(negedge CLK);
    do_step(6'b000000, 1, 1'b0);
    @(negedge CLK);
    #1;
    Reset = 1'b0;
    #1;
    check("abort_state", 8'(state), 8'd0);
    check("abort_strobes", act_strobes(), 8'd0);
    check("abort_dp", 8'({ExtSel, ALUSrcB, ALUOp, RegDst}), 8'd0);
    @(negedge CLK);
    Reset = 1'b1;
    run_instr(6'b000000, 2);

    // randomized
    for (int n = 0; n < 80; n++) run_instr(pick_op(), 2);

    // HALT held for 20+ cycles
    opcode    = 6'b111111;
    pcw_count = 0;
    for (int k = 0; k < 22; k++) begin
      do_step(6'b111111, k, 1'($urandom));
      @(negedge CLK);
    end
    check("halt_pcwre", 8'(pcw_count), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control unit for the teaching MIPS-style CPU. It sequences each instruction through fetch, decode, execute, memory and write-back states. It sits directly upstream of the program counter and drives its write-enable `PCWre` and branch-select `PCSrc`. It also drives the instruction-register, register-file, ALU and data-memory controls.

## Interface
- `OPW`, 6: opcode width (instruction bits [31:26]).
- `CLK` input 1: system clock; state register updates on rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `opcode` input OPW: opcode of the instruction held in the IR.
- `Zero` input 1: ALU zero flag, combinational from the current ALU result.
- `PCWre` output 1: PC write enable; one pulse per retired instruction.
- `PCSrc` output 1: 1 = branch target, 0 = PC+4.
- `IRWre` output 1: instruction register load.
- `ExtSel` output 1: 1 = sign-extend immediate, 0 = zero-extend.
- `ALUSrcB` output 1: 1 = immediate, 0 = rt.
- `ALUOp` output 3: ALU operation; 000 add, 001 sub, 011 or, 100 and, 110 slt.
- `RegDst` output 1: 1 = rd, 0 = rt.
- `RegWre` output 1: register-file write enable.
- `MemRd`, `MemWr` output 1 each: data-memory read and write.
- `DBDataSrc` output 1: 1 = memory data to write-back, 0 = ALU result.
- `Jump` output 1: only present with `CU_JUMP_EN`.
- `state` output 3: current state, for debug.

## Operation
- Opcodes:
  - ADD 000000, SUB 000001, ADDI 000010
  - OR 010000, AND 010001, ORI 010010
  - SLT 100111
  - SW 110000, LW 110001
  - BEQ 110100, BNE 110101
  - J 111000 (only with `CU_JUMP_EN`)
  - HALT 111111
- States: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101.
- IF → ID, always. `IRWre`=1 in IF only.
- ID:
  - HALT → HALT.
  - J → IF (with `CU_JUMP_EN`).
  - Any other legal opcode → EXE.
  - Illegal opcode → IF as a NOP, with `PCWre`=1 and no writes.
- EXE:
  - BEQ/BNE → IF.
  - LW/SW → MEM.
  - All others → WB.
- MEM: LW → WB; SW → IF.
- WB → IF.
- HALT is held until `Reset` is asserted.
- Outputs are combinational from (state, opcode, Zero).
  - `PCWre`=1 only in the final state of an instruction: ID for J/illegal, EXE for branches, MEM for SW, WB for ALU ops and LW. It is 0 everywhere else, including HALT.
  - `PCSrc`=1 only in EXE when (BEQ & Zero) | (BNE & ~Zero).
  - `ExtSel`=0 for ORI; 1 for ADDI, LW, SW, BEQ, BNE.
  - `ALUSrcB`=1 for ADDI, ORI, LW, SW.
  - `RegDst`=1 for R-type (ADD, SUB, OR, AND, SLT).
  - `ALUOp`=sub for BEQ/BNE and add for LW/SW.
- Datapath controls (`ExtSel`, `ALUSrcB`, `ALUOp`, `RegDst`) are valid from ID through the end of the instruction.
- Write and side-effect strobes:
  - `RegWre`=1 only in WB.
  - `MemRd`=1 only in MEM for LW.
  - `MemWr`=1 only in MEM for SW.
  - `DBDataSrc`=1 in WB for LW.
- Reset: while `Reset`=0, state=IF and every control output is forced to 0 (`state` reads 000). Asserting reset mid-instruction aborts it immediately, and no `RegWre`/`MemWr` pulse escapes.

## Timing
- State register updates on the rising `CLK` edge.
- The PC captures on the falling edge. Therefore `PCWre` and `PCSrc` must be settled within the first half-cycle of the final state; they come from registered state plus `Zero` only, with no combinational path from PC outputs.
- Cycles per instruction: ALU ops 4, LW 5, SW 4, BEQ/BNE 3, J 2, illegal 2.
- Exactly one `PCWre` pulse per instruction.
- After reset release, the first rising edge leaves IF.

## Configuration
- `CU_JUMP_EN`:
  - Defined: opcode 111000 is J. It takes ID → IF with `PCWre`=1 and `Jump`=1 in ID, and the `Jump` port exists.
  - Undefined: 111000 decodes as illegal (NOP path), and there is no `Jump` port.

## Structure
- Package `cu_pkg` holds:
  - the state encodings;
  - opcode localparams;
  - ALUOp constants;
  - an instruction-class typedef (ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, HALT, ILLEGAL).
- Sub-module `cu_decoder`: combinational opcode → class plus static datapath controls. The top level holds the FSM and the strobe gating.

## Test plan
- Reset low mid-EXE of an ADD: all outputs 0 and state=000 immediately. After release, IF with `IRWre`=1.
- ADD (000000): states IF, ID, EXE, WB. `RegWre`=1 and `PCWre`=1 only in WB, `RegDst`=1, `ALUOp`=000, 4 cycles.
- LW (110001): 5 states, `MemRd`=1 in MEM, `DBDataSrc`=1 and `RegWre`=1 in WB. SW (110000): `MemWr`=1 and `PCWre`=1 in MEM, `RegWre` never 1.
- BEQ with Zero=1 gives `PCSrc`=1 and `PCWre`=1 in EXE. BEQ with Zero=0 gives `PCSrc`=0. BNE with Zero=0 gives `PCSrc`=1. All take 3 cycles.
- HALT (111111): state 101 held for 20 cycles, `PCWre`=0 throughout.
- Opcode 111000: with `CU_JUMP_EN`, `Jump`=1 and `PCWre`=1 in ID, 2 cycles. Without it, NOP path, no writes.
